// File: rtl/cpu_controller_fsm.sv
// cpu_controller_fsm: Moore instruction sequencer for the 16-bit simple RISC CPU.
// It steps through fetch (IF1, IF2, UPD_PC), DECODE, and the per-instruction
// execute states. It also drives the register-file, ALU, PC and memory controls.
// Outputs are registered. The next state's output word is computed and loaded on
// the same edge as the state, so each output is a function of the current state.
// The exception is the conditional-branch PC load, which follows cond and the
// live status flags while the FSM sits in BRANCH.
//
// state_dbg encoding:
//   0 RST     1 IF1     2 IF2     3 UPD_PC  4 DECODE  5 WR_IMM  6 GET_A
//   7 GET_B   8 ALU     9 WR_REG 10 ADDR   11 LD_ADDR 12 RD1    13 RD2
//  14 GET_D  15 PASS   16 WR_MEM 17 BRANCH 18 LINK   19 JMP    20 LINKX
//  21 HALT
module cpu_controller_fsm #(
    parameter logic UNDEF_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    output logic       reset_pc,
    output logic       load_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic       load_ir,
    output logic [1:0] mem_cmd,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       halt,
    output logic [4:0] state_dbg
);

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF1     = 5'd1,
        S_IF2     = 5'd2,
        S_UPD_PC  = 5'd3,
        S_DECODE  = 5'd4,
        S_WR_IMM  = 5'd5,
        S_GET_A   = 5'd6,
        S_GET_B   = 5'd7,
        S_ALU     = 5'd8,
        S_WR_REG  = 5'd9,
        S_ADDR    = 5'd10,
        S_LD_ADDR = 5'd11,
        S_RD1     = 5'd12,
        S_RD2     = 5'd13,
        S_GET_D   = 5'd14,
        S_PASS    = 5'd15,
        S_WR_MEM  = 5'd16,
        S_BRANCH  = 5'd17,
        S_LINK    = 5'd18,
        S_JMP     = 5'd19,
        S_LINKX   = 5'd20,
        S_HALT    = 5'd21
    } state_t;

    // Control word: one field per datapath/memory control output.
    typedef struct packed {
        logic       reset_pc;
        logic       load_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic       load_ir;
        logic [1:0] mem_cmd;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       halt;
    } ctrl_t;

    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_BLINK  = 3'b010;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_MDATA = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b11;

    localparam logic [1:0] PCSEL_INC = 2'b00;
    localparam logic [1:0] PCSEL_REL = 2'b01;
    localparam logic [1:0] PCSEL_REG = 2'b10;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   br_load;

    // Branch condition evaluated against the status flags.
    function automatic logic cond_taken(input logic [2:0] c, input logic z,
                                        input logic n, input logic v);
        logic t;
        case (c)
            3'b000:  t = 1'b1;             // B   : always
            3'b001:  t = z;                // BEQ
            3'b010:  t = ~z;               // BNE
            3'b011:  t = n ^ v;            // BLT
            3'b100:  t = z | (n ^ v);      // BLE
            default: t = 1'b0;             // reserved: never taken
        endcase
        return t;
    endfunction

    // Dispatch from DECODE on the instruction class.
    function automatic state_t decode_dispatch(input logic [2:0] opc, input logic [1:0] o);
        state_t s;
        s = UNDEF_HALT ? S_HALT : S_IF1;
        case (opc)
            OPC_MOV: begin
                if (o == 2'b10)      s = S_WR_IMM;
                else if (o == 2'b00) s = S_GET_A;
            end
            OPC_ALU:    s = S_GET_A;
            OPC_LDR:    if (o == 2'b00) s = S_GET_A;
            OPC_STR:    if (o == 2'b00) s = S_GET_A;
            OPC_BRANCH: if (o == 2'b00) s = S_BRANCH;
            OPC_BLINK: begin
                if (o == 2'b11)                      s = S_LINK;
                else if (o == 2'b00 || o == 2'b10)   s = S_GET_D;
            end
            OPC_HALT:   s = S_HALT;
            default:    ;
        endcase
        return s;
    endfunction

    // Next-state transition. IR fields are stable from DECODE to the end of the
    // instruction, so shared states (GET_A, LD_ADDR, PASS) branch on them.
    function automatic state_t next_state(input state_t s, input logic [2:0] opc,
                                          input logic [1:0] o);
        state_t n;
        case (s)
            S_RST:     n = S_IF1;
            S_IF1:     n = S_IF2;
            S_IF2:     n = S_UPD_PC;
            S_UPD_PC:  n = S_DECODE;
            S_DECODE:  n = decode_dispatch(opc, o);
            S_WR_IMM:  n = S_IF1;
            S_GET_A:   n = (opc == OPC_LDR || opc == OPC_STR) ? S_ADDR : S_GET_B;
            S_GET_B:   n = S_ALU;
            // CMP only updates status, so it has no writeback.
            S_ALU:     n = (opc == OPC_ALU && o == 2'b01) ? S_IF1 : S_WR_REG;
            S_WR_REG:  n = S_IF1;
            S_ADDR:    n = S_LD_ADDR;
            S_LD_ADDR: n = (opc == OPC_LDR) ? S_RD1 : S_GET_D;
            S_RD1:     n = S_RD2;
            S_RD2:     n = S_IF1;
            S_GET_D:   n = S_PASS;
            S_PASS: begin
                if (opc == OPC_STR)                   n = S_WR_MEM;
                else if (opc == OPC_BLINK && o == 2'b10) n = S_LINKX;
                else                                  n = S_JMP;
            end
            S_WR_MEM:  n = S_IF1;
            S_BRANCH:  n = S_IF1;
            S_LINK:    n = S_IF1;
            // BLX: Rd has already been captured in C, so R7 can be overwritten.
            S_LINKX:   n = S_JMP;
            S_JMP:     n = S_IF1;
            S_HALT:    n = S_HALT;
            default:   n = S_RST;
        endcase
        return n;
    endfunction

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t state_outputs(input state_t s, input logic [2:0] opc,
                                            input logic [1:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPD_PC: begin
                c.load_pc = 1'b1;
                c.pc_sel  = PCSEL_INC;
            end
            S_WR_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM;
                c.write = 1'b1;
            end
            S_GET_A: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.loadc = 1'b1;
                c.asel  = (opc == OPC_MOV);
                c.loads = (opc == OPC_ALU) && (o == 2'b01);
            end
            S_WR_REG: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LD_ADDR: c.load_addr = 1'b1;
            S_RD1: begin
                c.addr_sel = 1'b0;
                c.mem_cmd  = MEM_READ;
            end
            S_RD2: begin
                c.addr_sel = 1'b0;
                c.mem_cmd  = MEM_READ;
                c.nsel     = NSEL_RD;
                c.vsel     = VSEL_MDATA;
                c.write    = 1'b1;
            end
            S_GET_D: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_WR_MEM: begin
                c.addr_sel = 1'b0;
                c.mem_cmd  = MEM_WRITE;
            end
            S_LINK: begin
                c.nsel    = NSEL_RN;
                c.vsel    = VSEL_PC;
                c.write   = 1'b1;
                c.load_pc = 1'b1;
                c.pc_sel  = PCSEL_REL;
            end
            S_JMP: begin
                c.load_pc = 1'b1;
                c.pc_sel  = PCSEL_REG;
            end
            S_LINKX: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_PC;
                c.write = 1'b1;
            end
            S_HALT: c.halt = 1'b1;
            default: c.mem_cmd = MEM_NONE;
        endcase
        return c;
    endfunction

    assign state_d = next_state(state_q, opcode, op);
    assign ctrl_d  = state_outputs(state_d, opcode, op);

    // State and registered control word; reset aborts any instruction at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_RST;
            ctrl_q           <= '0;
            ctrl_q.reset_pc  <= 1'b1;
            ctrl_q.load_pc   <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // A taken conditional branch loads PC+1+sximm8 from BRANCH.
    assign br_load = (state_q == S_BRANCH) && cond_taken(cond, Z, N, V);

    assign reset_pc  = ctrl_q.reset_pc;
    assign load_pc   = ctrl_q.load_pc | br_load;
    assign pc_sel    = br_load ? PCSEL_REL : ctrl_q.pc_sel;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_addr = ctrl_q.load_addr;
    assign load_ir   = ctrl_q.load_ir;
    assign mem_cmd   = ctrl_q.mem_cmd;
    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign write     = ctrl_q.write;
    assign halt      = ctrl_q.halt;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Testbench for cpu_controller_fsm.
// The bench combines a table of instruction records with hand-written expected
// cycle and activity counts, hand sequences for halt, undefined-opcode and
// asynchronous-reset aborts, and randomized instructions. Each DUT cycle is
// compared with an instruction-level reference model.
module tb_cpu_controller_fsm;

    localparam logic [4:0] S_RST = 5'd0, S_IF1 = 5'd1, S_IF2 = 5'd2, S_UPD = 5'd3,
                           S_DEC = 5'd4, S_WR_IMM = 5'd5, S_GET_A = 5'd6, S_GET_B = 5'd7,
                           S_ALU = 5'd8, S_WR_REG = 5'd9, S_ADDR = 5'd10, S_LD_ADDR = 5'd11,
                           S_RD1 = 5'd12, S_RD2 = 5'd13, S_GET_D = 5'd14, S_PASS = 5'd15,
                           S_WR_MEM = 5'd16, S_BRANCH = 5'd17, S_LINK = 5'd18, S_JMP = 5'd19,
                           S_LINKX = 5'd20, S_HALT = 5'd21;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic       Z, N, V;
    logic       reset_pc, load_pc, addr_sel, load_addr, load_ir;
    logic [1:0] pc_sel, mem_cmd, vsel;
    logic [2:0] nsel;
    logic       loada, loadb, asel, bsel, loadc, loads, write, halt;
    logic [4:0] state_dbg;

    always #5 clk = ~clk;

    cpu_controller_fsm #(.UNDEF_HALT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op), .cond(cond),
        .Z(Z), .N(N), .V(V),
        .reset_pc(reset_pc), .load_pc(load_pc), .pc_sel(pc_sel), .addr_sel(addr_sel),
        .load_addr(load_addr), .load_ir(load_ir), .mem_cmd(mem_cmd), .nsel(nsel),
        .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .loadc(loadc), .loads(loads), .write(write), .halt(halt), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       reset_pc;
        logic       load_pc;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic       load_ir;
        logic [1:0] mem_cmd;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       halt;
        logic [4:0] state;
    } outv_t;

    typedef struct {
        string      name;
        logic [2:0] opc;
        logic [1:0] o;
        logic [2:0] c;
        logic       z, n, v;
        int         cycles;   // IF1 through the last execute state
        int         writes;   // cycles with write=1
        int         memw;     // cycles with mem_cmd=WRITE
        int         drd;      // data reads: mem_cmd=READ with addr_sel=0
        int         rel;      // cycles loading PC with the PC-relative source
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] seq[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    function automatic outv_t actual();
        outv_t a;
        a = '{reset_pc, load_pc, pc_sel, addr_sel, load_addr, load_ir, mem_cmd, nsel,
              vsel, loada, loadb, asel, bsel, loadc, loads, write, halt, state_dbg};
        return a;
    endfunction

    task automatic check_vec(input string name, input outv_t a, input outv_t e);
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     name, a, e, a.state, e.state);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // Reference model: branch outcome from the condition table.
    function automatic logic br_taken(input logic [2:0] c, input logic z, input logic n,
                                      input logic v);
        int lt;
        lt = (int'(n) != int'(v)) ? 1 : 0;
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return lt == 1;
            3'd4:    return z || (lt == 1);
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: the list of steps an instruction walks through.
    task automatic build_seq(input logic [2:0] opc, input logic [1:0] o);
        seq = {S_IF1, S_IF2, S_UPD, S_DEC};
        if (opc == 3'b110 && o == 2'b10) seq.push_back(S_WR_IMM);
        else if ((opc == 3'b110 && o == 2'b00) || opc == 3'b101) begin
            seq.push_back(S_GET_A); seq.push_back(S_GET_B); seq.push_back(S_ALU);
            if (!(opc == 3'b101 && o == 2'b01)) seq.push_back(S_WR_REG);
        end else if (opc == 3'b011 && o == 2'b00)
            seq = {seq, S_GET_A, S_ADDR, S_LD_ADDR, S_RD1, S_RD2};
        else if (opc == 3'b100 && o == 2'b00)
            seq = {seq, S_GET_A, S_ADDR, S_LD_ADDR, S_GET_D, S_PASS, S_WR_MEM};
        else if (opc == 3'b001 && o == 2'b00) seq.push_back(S_BRANCH);
        else if (opc == 3'b010 && o == 2'b11) seq.push_back(S_LINK);
        else if (opc == 3'b010 && o == 2'b00) seq = {seq, S_GET_D, S_PASS, S_JMP};
        else if (opc == 3'b010 && o == 2'b10) seq = {seq, S_GET_D, S_PASS, S_LINKX, S_JMP};
        else seq.push_back(S_HALT);   // HALT and undefined encodings
    endtask

    // Reference model: expected outputs while sitting in a given step.
    function automatic outv_t model_out(input logic [4:0] st, input logic [2:0] opc,
                                        input logic [1:0] o, input logic tk);
        outv_t e;
        e = '0;
        e.state = st;
        case (st)
            S_RST:     begin e.reset_pc = 1; e.load_pc = 1; end
            S_IF1:     begin e.addr_sel = 1; e.mem_cmd = 2'b01; end
            S_IF2:     begin e.addr_sel = 1; e.mem_cmd = 2'b01; e.load_ir = 1; end
            S_UPD:     e.load_pc = 1;
            S_WR_IMM:  begin e.nsel = 3'b001; e.vsel = 2'b10; e.write = 1; end
            S_GET_A:   begin e.nsel = 3'b001; e.loada = 1; end
            S_GET_B:   begin e.nsel = 3'b100; e.loadb = 1; end
            S_ALU:     begin e.loadc = 1; e.asel = (opc == 3'b110);
                             e.loads = (opc == 3'b101 && o == 2'b01); end
            S_WR_REG:  begin e.nsel = 3'b010; e.write = 1; end
            S_ADDR:    begin e.bsel = 1; e.loadc = 1; end
            S_LD_ADDR: e.load_addr = 1;
            S_RD1:     e.mem_cmd = 2'b01;
            S_RD2:     begin e.mem_cmd = 2'b01; e.nsel = 3'b010; e.vsel = 2'b01; e.write = 1; end
            S_GET_D:   begin e.nsel = 3'b010; e.loadb = 1; end
            S_PASS:    begin e.asel = 1; e.loadc = 1; end
            S_WR_MEM:  e.mem_cmd = 2'b10;
            S_BRANCH:  if (tk) begin e.load_pc = 1; e.pc_sel = 2'b01; end
            S_LINK:    begin e.nsel = 3'b001; e.vsel = 2'b11; e.write = 1;
                             e.load_pc = 1; e.pc_sel = 2'b01; end
            S_JMP:     begin e.load_pc = 1; e.pc_sel = 2'b10; end
            S_LINKX:   begin e.nsel = 3'b001; e.vsel = 2'b11; e.write = 1; end
            S_HALT:    e.halt = 1;
            default:   ;
        endcase
        return e;
    endfunction

    task automatic add_vec(input string nm, input logic [2:0] opc, input logic [1:0] o,
                           input logic [2:0] c, input logic z, input logic n, input logic v,
                           input int cy, input int wr, input int mw, input int dr, input int rl);
        vec_t t;
        t.name = nm; t.opc = opc; t.o = o; t.c = c; t.z = z; t.n = n; t.v = v;
        t.cycles = cy; t.writes = wr; t.memw = mw; t.drd = dr; t.rel = rl;
        tbl.push_back(t);
    endtask

    // Entered #1 after the edge that put the DUT in IF1. Walks the instruction,
    // compares each cycle with the model, and stops at the next IF1 or after lim samples.
    task automatic run_instr(input string nm, input logic [2:0] opc, input logic [1:0] o,
                             input logic [2:0] c, input logic z, input logic n, input logic v,
                             input int lim, output int cyc, output int wr, output int mw,
                             output int dr, output int rl);
        outv_t a;
        logic  tk;
        int    k;
        opcode = opc; op = o; cond = c; Z = z; N = n; V = v;
        build_seq(opc, o);
        tk = br_taken(c, z, n, v);
        cyc = 0; wr = 0; mw = 0; dr = 0; rl = 0; k = 0;
        for (int t = 0; t < lim; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            a = actual();
            if (t > 0 && a.state == S_IF1) break;
            if (k < seq.size()) check_vec({nm, " step"}, a, model_out(seq[k], opc, o, tk));
            else check_int({nm, " overrun state"}, int'(a.state), int'(S_IF1));
            k++;
            cyc++;
            wr += int'(a.write);
            mw += int'(a.mem_cmd == 2'b10);
            dr += int'(a.mem_cmd == 2'b01 && !a.addr_sel);
            rl += int'(a.load_pc && a.pc_sel == 2'b01);
        end
    endtask

    // Entered #1 after an edge. Pulls reset low between edges, checks the
    // immediate RST state, then releases it and checks the return to IF1.
    task automatic reset_pulse(input string nm);
        #2 reset_n = 1'b0;
        #1 check_vec({nm, " async RST"}, actual(), model_out(S_RST, 3'b000, 2'b00, 1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_int({nm, " back to IF1"}, int'(state_dbg), int'(S_IF1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, wr, mw, dr, rl;
        logic [2:0] r_opc, r_c;
        logic [1:0] r_o;
        logic r_z, r_n, r_v;
        int pick;

        add_vec("MOVI",  3'b110, 2'b10, 3'd0, 0, 0, 0,  5, 1, 0, 0, 0);
        add_vec("MOVR",  3'b110, 2'b00, 3'd0, 0, 0, 0,  8, 1, 0, 0, 0);
        add_vec("ADD",   3'b101, 2'b00, 3'd0, 0, 0, 0,  8, 1, 0, 0, 0);
        add_vec("CMP",   3'b101, 2'b01, 3'd0, 0, 0, 0,  7, 0, 0, 0, 0);
        add_vec("AND",   3'b101, 2'b10, 3'd0, 0, 0, 0,  8, 1, 0, 0, 0);
        add_vec("MVN",   3'b101, 2'b11, 3'd0, 0, 0, 0,  8, 1, 0, 0, 0);
        add_vec("STR",   3'b100, 2'b00, 3'd0, 0, 0, 0, 10, 0, 1, 0, 0);
        add_vec("LDR",   3'b011, 2'b00, 3'd0, 0, 0, 0,  9, 1, 0, 2, 0);
        add_vec("B",     3'b001, 2'b00, 3'd0, 0, 0, 0,  5, 0, 0, 0, 1);
        add_vec("BEQnt", 3'b001, 2'b00, 3'd1, 0, 0, 0,  5, 0, 0, 0, 0);
        add_vec("BNE",   3'b001, 2'b00, 3'd2, 0, 0, 0,  5, 0, 0, 0, 1);
        add_vec("BLT",   3'b001, 2'b00, 3'd3, 0, 1, 0,  5, 0, 0, 0, 1);
        add_vec("BLTnt", 3'b001, 2'b00, 3'd3, 0, 1, 1,  5, 0, 0, 0, 0);
        add_vec("BLE",   3'b001, 2'b00, 3'd4, 1, 0, 0,  5, 0, 0, 0, 1);
        add_vec("Bresv", 3'b001, 2'b00, 3'd5, 1, 1, 0,  5, 0, 0, 0, 0);
        add_vec("BL",    3'b010, 2'b11, 3'd0, 0, 0, 0,  5, 1, 0, 0, 1);
        add_vec("BX",    3'b010, 2'b00, 3'd0, 0, 0, 0,  7, 0, 0, 0, 0);
        add_vec("BLX",   3'b010, 2'b10, 3'd0, 0, 0, 0,  8, 1, 0, 0, 0);

        reset_n = 1'b0; opcode = '0; op = '0; cond = '0; Z = 0; N = 0; V = 0;
        repeat (2) @(posedge clk);
        #1 check_vec("reset held", actual(), model_out(S_RST, 3'b000, 2'b00, 1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check_int("first edge IF1", int'(state_dbg), int'(S_IF1));

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].opc, tbl[i].o, tbl[i].c, tbl[i].z, tbl[i].n,
                      tbl[i].v, 24, cyc, wr, mw, dr, rl);
            check_int({tbl[i].name, " cycles"}, cyc, tbl[i].cycles);
            check_int({tbl[i].name, " writes"}, wr, tbl[i].writes);
            check_int({tbl[i].name, " mem writes"}, mw, tbl[i].memw);
            check_int({tbl[i].name, " data reads"}, dr, tbl[i].drd);
            check_int({tbl[i].name, " rel pc loads"}, rl, tbl[i].rel);
        end

        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 11));
            case (pick)
                0:  begin r_opc = 3'b110; r_o = 2'b10; end
                1:  begin r_opc = 3'b110; r_o = 2'b00; end
                2:  begin r_opc = 3'b101; r_o = 2'b00; end
                3:  begin r_opc = 3'b101; r_o = 2'b01; end
                4:  begin r_opc = 3'b101; r_o = 2'b10; end
                5:  begin r_opc = 3'b101; r_o = 2'b11; end
                6:  begin r_opc = 3'b011; r_o = 2'b00; end
                7:  begin r_opc = 3'b100; r_o = 2'b00; end
                8:  begin r_opc = 3'b001; r_o = 2'b00; end
                9:  begin r_opc = 3'b010; r_o = 2'b11; end
                10: begin r_opc = 3'b010; r_o = 2'b00; end
                default: begin r_opc = 3'b010; r_o = 2'b10; end
            endcase
            r_c = 3'($urandom_range(0, 7));
            r_z = 1'($urandom_range(0, 1));
            r_n = 1'($urandom_range(0, 1));
            r_v = 1'($urandom_range(0, 1));
            run_instr("RND", r_opc, r_o, r_c, r_z, r_n, r_v, 24, cyc, wr, mw, dr, rl);
            check_int("RND cycles", cyc, seq.size());
        end

        // Reset in the middle of LDR, at its first data-read cycle.
        run_instr("LDR abort", 3'b011, 2'b00, 3'd0, 0, 0, 0, 8, cyc, wr, mw, dr, rl);
        check_int("LDR abort at RD1", int'(state_dbg), int'(S_RD1));
        reset_pulse("LDR abort");

        // An undefined encoding halts with the default parameter.
        run_instr("UNDEF", 3'b000, 2'b01, 3'd0, 0, 0, 0, 5, cyc, wr, mw, dr, rl);
        reset_pulse("UNDEF");

        // HALT holds for 20 cycles; only reset leaves it.
        run_instr("HALT", 3'b111, 2'b00, 3'd0, 0, 0, 0, 5, cyc, wr, mw, dr, rl);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 check_vec("HALT hold", actual(), model_out(S_HALT, 3'b111, 2'b00, 1'b0));
        end
        reset_pulse("HALT");

        run_instr("post MOVI", 3'b110, 2'b10, 3'd0, 0, 0, 0, 24, cyc, wr, mw, dr, rl);
        check_int("post MOVI cycles", cyc, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_controller_fsm.md
Name: cpu_controller_fsm

Overview:
- Moore-style instruction sequencer for the 16-bit simple RISC CPU.
- Drives instruction fetch, PC update, the datapath (register file, A/B/C registers, ALU, status) and the 256x16 synchronous-read memory interface.
- Sits inside the CPU, between the instruction register/decoder and the datapath/memory muxes.
- Replaces ad-hoc per-lab control and adds branch/link sequencing.

Parameters:
UNDEF_HALT, 0, 1: undefined encodings enter HALT; 0: undefined encodings act as a NOP and return to IF1.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
opcode  in  3  IR[15:13].
op  in  2  IR[12:11].
cond  in  3  IR[10:8].
Z, N, V  in  1 each  status register outputs.
reset_pc  out  1  PC mux selects 0.
load_pc  out  1  PC register enable.
pc_sel  out  2  next-PC source: 00 PC+1, 01 PC+sximm8, 10 datapath C.
addr_sel  out  1  memory address source: 1 PC, 0 address register.
load_addr  out  1  address register enable (captures C[8:0]).
load_ir  out  1  IR enable.
mem_cmd  out  2  memory command: 00 NONE, 01 READ, 10 WRITE.
nsel  out  3  register select, one-hot: 001 Rn, 010 Rd, 100 Rm.
vsel  out  2  writeback source: 00 C, 01 mdata, 10 sximm8, 11 PC.
loada  out  1  A register enable.
loadb  out  1  B register enable.
asel  out  1  1 forces ALU A input to 0.
bsel  out  1  1 selects sximm5 on ALU B input.
loadc  out  1  C register enable.
loads  out  1  status register enable.
write  out  1  register file write enable.
halt  out  1  high in HALT; drives LEDR[8].
state_dbg  out  5  current state encoding.

Behaviour:
- Reset: while reset_n=0, state=RST asynchronously. RST outputs reset_pc=1, load_pc=1, all other outputs 0. The first rising edge after release goes to IF1. reset_n low in any state aborts the current instruction.
- Unlisted outputs are 0 in each state. All outputs are pure functions of state, except load_pc in BRANCH (depends on cond and flags).
- Fetch:
  - IF1: addr_sel=1, mem_cmd=READ.
  - IF2: addr_sel=1, mem_cmd=READ, load_ir=1.
  - UPD_PC: load_pc=1, pc_sel=00.
  - DECODE: no outputs; dispatches on opcode/op.
- MOV imm (110,10): WR_IMM (nsel=Rn, vsel=10, write) -> IF1. 5 cycles.
- MOV reg (110,00) and ALU (101,xx):
  - GET_A: nsel=Rn, loada.
  - GET_B: nsel=Rm, loadb.
  - ALU: loadc. asel=1 for MOV only. loads=1 for CMP (op 01) only.
  - WR_REG: nsel=Rd, vsel=00, write. Skipped for CMP.
  - Then IF1. ADD/AND/MVN/MOV take 8 cycles; CMP takes 7.
- LDR (011,00): GET_A -> ADDR (bsel=1, loadc) -> LD_ADDR (load_addr) -> RD1 (addr_sel=0, READ) -> RD2 (addr_sel=0, READ, nsel=Rd, vsel=01, write) -> IF1.
- STR (100,00): GET_A -> ADDR -> LD_ADDR -> GET_D (nsel=Rd, loadb) -> PASS (asel=1, loadc) -> WR_MEM (addr_sel=0, WRITE) -> IF1.
- Conditional branch (001,00), BRANCH state:
  - Taken condition by cond: 000 always; 001 Z; 010 ~Z; 011 N!=V; 100 Z|(N!=V); others never.
  - If taken: load_pc=1, pc_sel=01.
  - Always returns to IF1.
  - PC already holds PC+1, so target = PC+1+sximm8.
- BL (010,11): LINK (nsel=Rn, vsel=11, write, load_pc, pc_sel=01) -> IF1.
- BX (010,00): GET_D -> PASS -> JMP (load_pc, pc_sel=10) -> IF1.
- BLX (010,10): GET_D -> PASS -> LINKX (nsel=Rn, vsel=11, write) -> JMP. Rd is read before R7 is overwritten.
- HALT (111): HALT state, halt=1, self-loop. Only reset_n exits.
- Undefined encodings go to HALT if UNDEF_HALT=1, otherwise IF1.
- PC arithmetic (9-bit wrap) belongs to the datapath. The FSM only selects the source.

Test Plan:
- Reset then release: reset_n=0 for 2 cycles -> state RST, reset_pc=1, load_pc=1. First edge after release -> IF1. IF2 has load_ir=1.
- MOV R1,#5 (0xD105): state sequence IF1,IF2,UPD_PC,DECODE,WR_IMM,IF1. At WR_IMM: nsel=001, vsel=10, write=1.
- CMP (0xA9xx) with Z=0: sequence ...GET_A,GET_B,ALU,IF1. loads=1 only in ALU; write never asserted.
- BLT with N=1,V=0 -> BRANCH load_pc=1, pc_sel=01. Repeat with N=1,V=1 -> load_pc=0, next state IF1.
- STR then LDR: STR has exactly one mem_cmd=10 cycle with addr_sel=0. LDR has two READ cycles with addr_sel=0; write=1 with vsel=01 in the second.
- HALT (0xE000): halt=1 held for 20 cycles, load_pc=0. Pulse reset_n low mid-HALT -> RST immediately (asynchronous), halt=0.
